div16_seq: RTL and testbench

Sequential 16-bit unsigned restoring divider, the inverse-direction companion to the 16-bit carry-lookahead adder datapath. It takes a dividend/divisor pair on a single-cycle start strobe and iterates one quotient bit per clock using a 17-bit trial subtraction. It returns the quotient and remainder with a one-cycle done pulse. It sits beside the adder in the arithmetic datapath and is driven by the same control logic and benches.

---
 rtl/div16_seq.sv | 114 +++++++++++
 tb/tb_div16_seq.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/div16_seq.sv
// Sequential 16-bit unsigned restoring divider: one quotient bit per clock, done pulse on completion.
// Optional build macro DIV16_ZERO_FLAG_EN: short-circuit a zero divisor and raise div_by_zero.
module div16_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] dividend,
    input  logic [15:0] divisor,
    output logic [15:0] quotient,
    output logic [15:0] remainder,
    output logic        busy,
    output logic        done,
    output logic        div_by_zero
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t      state;
    logic [15:0] dvsr;
    logic [15:0] dq;
    logic [15:0] rem;
    logic [3:0]  count;

    logic [16:0] rem_shift;
    logic [16:0] trial;
    logic [15:0] rem_next;
    logic [15:0] dq_next;

`ifdef DIV16_ZERO_FLAG_EN
    logic dbz_q;
    assign div_by_zero = dbz_q;
`else
    assign div_by_zero = 1'b0;
`endif

    // The stored remainder is always below the divisor, so it fits in 16 bits;
    // the 17th bit exists only in the shifted trial operand.
    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        rem_shift = {rem, dq[15]};
        trial     = rem_shift - {1'b0, dvsr};
        dq_next   = {dq[14:0], 1'b0};
        rem_next  = rem_shift[15:0];
        if (!trial[16]) begin
            rem_next   = trial[15:0];
            dq_next[0] = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // sees the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            count     <= '0;
            dvsr      <= '0;
            dq        <= '0;
            rem       <= '0;
            quotient  <= '0;
            remainder <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef DIV16_ZERO_FLAG_EN
            dbz_q     <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        dvsr  <= divisor;
                        dq    <= dividend;
                        rem   <= '0;
                        count <= '0;
`ifdef DIV16_ZERO_FLAG_EN
                        dbz_q <= (divisor == 16'd0);
                        if (divisor == 16'd0) begin
                            quotient  <= 16'hFFFF;
                            remainder <= dividend;
                            done      <= 1'b1;
                            state     <= DONE;
                        end else begin
                            busy  <= 1'b1;
                            state <= RUN;
                        end
`else
                        busy  <= 1'b1;
                        state <= RUN;
`endif
                    end
                end
                RUN: begin
                    rem   <= rem_next;
                    dq    <= dq_next;
                    count <= count + 4'd1;
                    if (count == 4'd15) begin
                        quotient  <= dq_next;
                        remainder <= rem_next;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div16_seq.sv
// Self-checking bench for div16_seq: directed cases plus random pairs against an arithmetic model.
module tb_div16_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] dividend;
    logic [15:0] divisor;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        busy;
    logic        done;
    logic        div_by_zero;

    int checks   = 0;
    int failures = 0;

`ifdef DIV16_ZERO_FLAG_EN
    localparam bit ZF = 1'b1;
`else
    localparam bit ZF = 1'b0;
`endif

    div16_seq dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .quotient   (quotient),
        .remainder  (remainder),
        .busy       (busy),
        .done       (done),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic [15:0] a, input logic [15:0] b,
                                  output logic [15:0] q, output logic [15:0] r);
        if (b == 16'd0) begin
            q = 16'hFFFF;
            r = a;
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    // Called at a falling edge with the DUT in IDLE; returns at the falling edge after DONE.
    // inject_at >= 0 raises a stray 200/3 start in that RUN cycle.
    task automatic run_div(input string tag, input logic [15:0] a, input logic [15:0] b,
                           input int inject_at);
        logic [15:0] eq;
        logic [15:0] er;
        int lat;
        int nbusy;
        bit zf_path;
        model(a, b, eq, er);
        zf_path  = ZF && (b == 16'd0);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat   = 0;
        nbusy = 0;
        check({tag, ":dbz_after_accept"}, 32'(div_by_zero), 32'(zf_path));
        while (done !== 1'b1 && lat < 40) begin
            if (busy === 1'b1) nbusy++;
            if (lat == inject_at) begin
                dividend = 16'd200;
                divisor  = 16'd3;
                start    = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        start = 1'b0;
        check({tag, ":latency"}, lat, zf_path ? 32'd0 : 32'd16);
        check({tag, ":busy_cycles"}, nbusy, zf_path ? 32'd0 : 32'd16);
        check({tag, ":busy_at_done"}, 32'(busy), 32'd0);
        check({tag, ":quotient"}, 32'(quotient), 32'(eq));
        check({tag, ":remainder"}, 32'(remainder), 32'(er));
        check({tag, ":dbz"}, 32'(div_by_zero), 32'(zf_path));
        if (b != 16'd0) begin
            check({tag, ":identity"}, 32'(quotient) * 32'(b) + 32'(remainder), 32'(a));
            check({tag, ":rem_lt_div"}, 32'(remainder < b), 32'd1);
        end
        @(negedge clk);
        check({tag, ":done_one_cycle"}, 32'(done), 32'd0);
        check({tag, ":quotient_held"}, 32'(quotient), 32'(eq));
    endtask

    initial begin
        int extra_done;
        int extra_busy;
        logic [15:0] ra;
        logic [15:0] rb;

        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset:quotient", 32'(quotient), 32'd0);
        check("reset:remainder", 32'(remainder), 32'd0);
        check("reset:busy", 32'(busy), 32'd0);
        check("reset:done", 32'(done), 32'd0);
        check("reset:dbz", 32'(div_by_zero), 32'd0);

        run_div("100/7", 16'd100, 16'd7, -1);
        check("100/7:q_const", 32'(quotient), 32'd14);
        check("100/7:r_const", 32'(remainder), 32'd2);

        // Back to back: each call launches at the first falling edge after DONE.
        run_div("65535/1", 16'd65535, 16'd1, -1);
        run_div("12/10", 16'd12, 16'd10, -1);
        run_div("5/9", 16'd5, 16'd9, -1);

        // A start during RUN must neither change the result nor queue a second run.
        run_div("100/7_inject", 16'd100, 16'd7, 5);
        extra_done = 0;
        extra_busy = 0;
        repeat (20) begin
            @(negedge clk);
            if (done === 1'b1) extra_done++;
            if (busy === 1'b1) extra_busy++;
        end
        check("inject:extra_done", extra_done, 32'd0);
        check("inject:extra_busy", extra_busy, 32'd0);
        check("inject:q_const", 32'(quotient), 32'd14);

        // Reset landing on the edge of iteration 8.
        dividend = 16'd1000;
        divisor  = 16'd7;
        start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        check("rst_mid:busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid:quotient", 32'(quotient), 32'd0);
        check("rst_mid:remainder", 32'(remainder), 32'd0);
        check("rst_mid:busy", 32'(busy), 32'd0);
        check("rst_mid:done", 32'(done), 32'd0);
        rst = 1'b0;
        extra_done = 0;
        extra_busy = 0;
        repeat (20) begin
            @(negedge clk);
            if (done === 1'b1) extra_done++;
            if (busy === 1'b1) extra_busy++;
        end
        check("rst_mid:no_done", extra_done, 32'd0);
        check("rst_mid:no_busy", extra_busy, 32'd0);
        run_div("1000/7", 16'd1000, 16'd7, -1);
        check("1000/7:q_const", 32'(quotient), 32'd142);
        check("1000/7:r_const", 32'(remainder), 32'd6);

        run_div("1234/0", 16'd1234, 16'd0, -1);
        check("1234/0:q_const", 32'(quotient), 32'hFFFF);
        check("1234/0:r_const", 32'(remainder), 32'd1234);

        // The next accepted start clears the zero-divisor flag (checked inside run_div).
        for (int i = 0; i < 20; i++) begin
            ra = 16'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(1, 15))
                                             : 16'($urandom_range(1, 65535));
            run_div($sformatf("rand%0d", i), ra, rb, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
